cmac_acc: RTL

Complex accumulate stage directly downstream of the complex multiplier in the PE datapath. Consumes a stream of packed complex products {real, imag}, sums a variable-length run of them at full precision, then applies a programmable arithmetic right shift and saturates the result back to DATA_WIDTH per component. One result is emitted per run over a valid/ready handshake, giving the PE a dot-product / correlation primitive without round-tripping partial sums through the register file.

---
 rtl/cmac_acc.sv | 123 ++++++++++++
 1 files changed

// File: rtl/cmac_acc.sv
// Complex accumulate stage: sums a run of packed {real, imag} products at full
// precision, then arithmetic-shifts and saturates the sum back to DATA_WIDTH.
//
// state  | meaning
// -------+----------------------------------------------------------------
// ST_ACC | accepting samples, accumulating the current run
// ST_OUT | result held on out_data until downstream takes it
module cmac_acc #(
    parameter int DATA_WIDTH = 16,
    parameter int GUARD      = 8,
    parameter int MAX_LEN    = 256
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [2*DATA_WIDTH-1:0]          in_data,
    input  logic                             in_last,
    input  logic [4:0]                       shift,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [2*DATA_WIDTH-1:0]          out_data,
    output logic                             out_sat,
    output logic [$clog2(MAX_LEN+1)-1:0]     out_cnt
);

    localparam int DW    = DATA_WIDTH;
    localparam int ACC_W = DATA_WIDTH + GUARD;
    localparam int CNT_W = $clog2(MAX_LEN + 1);

    localparam logic signed [ACC_W-1:0] MAX_V = {{(GUARD+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MIN_V = {{(GUARD+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DW-1:0]           SAT_HI = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]           SAT_LO = {1'b1, {(DW-1){1'b0}}};
    localparam logic [CNT_W-1:0]        LAST_CNT = CNT_W'(MAX_LEN - 1);

    typedef enum logic {ST_ACC, ST_OUT} state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc_r, acc_i;
    logic [CNT_W-1:0]        cnt;
    logic [4:0]              shift_q;

    logic                    accept, first, run_end;
    logic [CNT_W-1:0]        cnt_inc;
    logic [4:0]              shift_eff;
    logic signed [ACC_W-1:0] smp_r, smp_i, sum_r, sum_i, shr_r, shr_i;
    logic [DW:0]             sat_r, sat_i;

    // Returns {saturated, value}.
    function automatic logic [DW:0] sat_fn(input logic signed [ACC_W-1:0] v);
        if (v > MAX_V)
            return {1'b1, SAT_HI};
        else if (v < MIN_V)
            return {1'b1, SAT_LO};
        else
            return {1'b0, v[DW-1:0]};
    endfunction

    assign in_ready  = (state == ST_ACC);
    assign out_valid = (state == ST_OUT);

    assign accept    = in_valid && in_ready;
    assign first     = (cnt == '0);
    assign run_end   = accept && (in_last || cnt == LAST_CNT);
    assign cnt_inc   = cnt + CNT_W'(1);
    // The first sample's shift takes effect for the result of a single-sample run.
    assign shift_eff = first ? shift : shift_q;

    assign smp_r = {{GUARD{in_data[2*DW-1]}}, in_data[2*DW-1:DW]};
    assign smp_i = {{GUARD{in_data[DW-1]}},   in_data[DW-1:0]};
    assign sum_r = first ? smp_r : acc_r + smp_r;
    assign sum_i = first ? smp_i : acc_i + smp_i;
    assign shr_r = sum_r >>> shift_eff;
    assign shr_i = sum_i >>> shift_eff;
    assign sat_r = sat_fn(shr_r);
    assign sat_i = sat_fn(shr_i);

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_ACC;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_ACC: if (run_end)   state_nxt = ST_OUT;
            ST_OUT: if (out_ready) state_nxt = ST_ACC;
            default:               state_nxt = ST_ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r    <= '0;
            acc_i    <= '0;
            cnt      <= '0;
            shift_q  <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
            out_cnt  <= '0;
        end else if (accept) begin
            acc_r <= sum_r;
            acc_i <= sum_i;
            cnt   <= cnt_inc;
            if (first)
                shift_q <= shift;
            if (run_end) begin
                out_data <= {sat_r[DW-1:0], sat_i[DW-1:0]};
                out_sat  <= sat_r[DW] | sat_i[DW];
                out_cnt  <= cnt_inc;
            end
        end else if (out_valid && out_ready) begin
            acc_r <= '0;
            acc_i <= '0;
            cnt   <= '0;
        end
    end

endmodule
